// File: rtl/rcv_pkg.sv
// Shared types and widths for the rcv_block drain controller.
`timescale 1ns/1ps
package rcv_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } rcv_ctrl_state_t;

endpackage

// File: rtl/rcv_byte_fifo.sv
// Small byte FIFO with registered head/valid/count.
// Push into a full FIFO and pop from an empty FIFO are ignored.
`timescale 1ns/1ps
module rcv_byte_fifo
  import rcv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [BYTE_W-1:0]       wr_data,
  output logic [BYTE_W-1:0]       head,
  output logic                    valid,
  output logic                    full_c,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_c = (cnt_q == CNT_W'(DEPTH));
  assign count  = cnt_q;

  // Next storage/pointer/occupancy; full and empty use the pre-pop count.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push && (cnt_q != CNT_W'(DEPTH));
    do_pop  = pop && (cnt_q != '0);
    if (do_push) begin
      mem_d[wr_q] = wr_data;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and registered head view.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      head  <= '0;
      valid <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      head  <= mem_d[rd_d];
      valid <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/rcv_rx_ctrl.sv
// Drain controller for rcv_block: captures bytes into a FIFO, pulses
// data_read, streams bytes out on valid/ready and tracks error events.
// Optional feature macro: RCV_ERR_STATS_EN (saturating error counters).
`timescale 1ns/1ps
module rcv_rx_ctrl
  import rcv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          data_ready,
  input  logic                          overrun_error,
  input  logic                          framing_error,
  output logic                          data_read,
  output logic [BYTE_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          err_clear,
  output logic                          overrun_seen,
  output logic                          framing_seen,
  output logic [ERR_CNT_WIDTH-1:0]      overrun_cnt,
  output logic [ERR_CNT_WIDTH-1:0]      framing_cnt
);

  rcv_ctrl_state_t state_q, state_d;
  logic            push_c;
  logic            full_c;
  logic            ovr_prev_q, frm_prev_q;
  logic            ovr_rise_c, frm_rise_c;

  rcv_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (push_c),
    .pop     (out_ready),
    .wr_data (rx_data),
    .head    (out_data),
    .valid   (out_valid),
    .full_c  (full_c),
    .count   (fifo_count)
  );

  // State and registered release pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      data_read <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_read <= (state_d == ACK);
    end
  end

  // Next state; push only on the IDLE->ACK transition so a byte is taken once.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_ready && !full_c) begin
          push_c  = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_CLR;
      WAIT_CLR: if (!data_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign ovr_rise_c = overrun_error & ~ovr_prev_q;
  assign frm_rise_c = framing_error & ~frm_prev_q;

  // Edge history and sticky flags; clear beats a coincident set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovr_prev_q   <= 1'b0;
      frm_prev_q   <= 1'b0;
      overrun_seen <= 1'b0;
      framing_seen <= 1'b0;
    end else begin
      ovr_prev_q <= overrun_error;
      frm_prev_q <= framing_error;
      if (err_clear) begin
        overrun_seen <= 1'b0;
        framing_seen <= 1'b0;
      end else begin
        if (ovr_rise_c) overrun_seen <= 1'b1;
        if (frm_rise_c) framing_seen <= 1'b1;
      end
    end
  end

`ifdef RCV_ERR_STATS_EN
  // Saturating event counters; clear beats a coincident increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_cnt <= '0;
      framing_cnt <= '0;
    end else if (err_clear) begin
      overrun_cnt <= '0;
      framing_cnt <= '0;
    end else begin
      if (ovr_rise_c && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + ERR_CNT_WIDTH'(1);
      if (frm_rise_c && (framing_cnt != '1)) framing_cnt <= framing_cnt + ERR_CNT_WIDTH'(1);
    end
  end
`else
  assign overrun_cnt = '0;
  assign framing_cnt = '0;
`endif

endmodule

// File: tb/tb_rcv_rx_ctrl.sv
// Directed bench for rcv_rx_ctrl with a byte scoreboard on the output stream.
`timescale 1ns/1ps
module tb_rcv_rx_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic [7:0]    rx_data;
  logic          data_ready, overrun_error, framing_error;
  logic          data_read;
  logic [7:0]    out_data;
  logic          out_valid, out_ready;
  logic [2:0]    fifo_count;
  logic          err_clear, overrun_seen, framing_seen;
  logic [CW-1:0] overrun_cnt, framing_cnt;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q [$];

  always #1.25 tb_clk = ~tb_clk;

  rcv_rx_ctrl #(.FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(CW)) dut (
    .clk           (tb_clk),
    .n_rst         (n_rst),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .data_read     (data_read),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .fifo_count    (fifo_count),
    .err_clear     (err_clear),
    .overrun_seen  (overrun_seen),
    .framing_seen  (framing_seen),
    .overrun_cnt   (overrun_cnt),
    .framing_cnt   (framing_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #0.5;
  endtask

  // Scoreboard: a byte leaves on the next edge whenever valid & ready.
  always @(negedge tb_clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
      else check("stream_byte", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  // Offer one byte, wait (bounded) for the release pulse, then return to IDLE.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    rx_data    = b;
    data_ready = 1'b1;
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (data_read) begin
        got = 1;
        break;
      end
    end
    if (!got) check("ack_timeout", 32'(data_read), 32'd1);
    data_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && fifo_count != 0; i++) tick();
    out_ready = 1'b0;
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [CW-1:0] exp_ovr, exp_frm, exp_sat;
`ifdef RCV_ERR_STATS_EN
    exp_ovr = CW'(2); exp_frm = CW'(1); exp_sat = '1;
`else
    exp_ovr = '0; exp_frm = '0; exp_sat = '0;
`endif
    n_rst = 1'b1; rx_data = '0; data_ready = 1'b1; overrun_error = 1'b0;
    framing_error = 1'b0; out_ready = 1'b0; err_clear = 1'b0;
    #1 n_rst = 1'b0;

    // Reset with data_ready held high
    tick(); tick();
    check("rst_data_read", 32'(data_read), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_flags", 32'({overrun_seen, framing_seen}), 32'd0);
    data_ready = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();

    // Single byte, consumer stalled then released
    rx_data = 8'hD5; data_ready = 1'b1; exp_q.push_back(8'hD5);
    tick();
    check("single_data_read", 32'(data_read), 32'd1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_head", 32'(out_data), 32'hD5);
    check("single_count", 32'(fifo_count), 32'd1);
    data_ready = 1'b0;
    tick();
    check("single_pulse_end", 32'(data_read), 32'd0);
    out_ready = 1'b1;
    tick();
    check("single_pop_count", 32'(fifo_count), 32'd0);
    check("single_pop_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();

    // Fill to full, fifth byte back-pressured until space frees
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    check("fill_count", 32'(fifo_count), 32'd4);
    rx_data = 8'h05; data_ready = 1'b1; exp_q.push_back(8'h05);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_ack", 32'(data_read), 32'd0);
    end
    check("full_count_hold", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (data_read) begin
          got = 1;
          break;
        end
      end
      check("fifth_acked", 32'(got), 32'd1);
      check("fifth_count", 32'(fifo_count), 32'd3);
    end
    data_ready = 1'b0;
    drain();
    tick(); tick();

    // Push and pop in the same cycle at count 2
    send_byte(8'hA1);
    send_byte(8'hA2);
    check("pp_pre_count", 32'(fifo_count), 32'd2);
    rx_data = 8'hA3; data_ready = 1'b1; exp_q.push_back(8'hA3); out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd2);
    check("pp_data_read", 32'(data_read), 32'd1);
    check("pp_head", 32'(out_data), 32'hA2);
    data_ready = 1'b0;
    tick(); tick();
    drain();

    // Error edges, sticky flags and counters
    for (int i = 0; i < 2; i++) begin
      overrun_error = 1'b1; tick(); overrun_error = 1'b0; tick();
    end
    framing_error = 1'b1; tick(); tick(); framing_error = 1'b0; tick();
    check("ovr_seen", 32'(overrun_seen), 32'd1);
    check("frm_seen", 32'(framing_seen), 32'd1);
    check("ovr_cnt", 32'(overrun_cnt), 32'(exp_ovr));
    check("frm_cnt", 32'(framing_cnt), 32'(exp_frm));
    check("frm_no_push", 32'(fifo_count), 32'd0);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("clr_flags", 32'({overrun_seen, framing_seen}), 32'd0);
    check("clr_cnts", 32'({overrun_cnt, framing_cnt}), 32'd0);
    overrun_error = 1'b1; err_clear = 1'b1; tick();
    overrun_error = 1'b0; err_clear = 1'b0; tick();
    check("clr_beats_set", 32'(overrun_seen), 32'd0);
    check("clr_beats_inc", 32'(overrun_cnt), 32'd0);
    for (int i = 0; i < 256; i++) begin
      overrun_error = 1'b1; tick(); overrun_error = 1'b0; tick();
    end
    check("ovr_saturate", 32'(overrun_cnt), 32'(exp_sat));
    check("ovr_seen_again", 32'(overrun_seen), 32'd1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;

    // Reset asserted while the release pulse is high
    rx_data = 8'h3C; data_ready = 1'b1; exp_q.push_back(8'h3C);
    tick();
    check("ack_before_rst", 32'(data_read), 32'd1);
    #0.2 n_rst = 1'b0;
    #0.1;
    check("async_data_read", 32'(data_read), 32'd0);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    data_ready = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    check("post_rst_data_read", 32'(data_read), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
